// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: pipeline-side signal bundle of the hazard unit
// Carries the D/E/M/W register fields and controls, the multi-cycle unit
// handshakes and every hazard-unit output. master = pipeline, slave = hazard unit.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 4,
    parameter int NUM_MC = 2,
    parameter int CNT_W  = 16
);
    localparam int NUM_REGS = 2**REG_AW;
    logic [REG_AW-1:0]        RA1D, RA2D, WA3D;
    logic                     RegWriteD;
    logic [NUM_MC-1:0]        McReqD;
    logic [REG_AW-1:0]        RA1E, RA2E, WA3E;
    logic                     RegWriteE, MemtoRegE;
    logic [NUM_MC-1:0]        McStartE;
    logic [REG_AW-1:0]        RA2M, WA3M;
    logic                     RegWriteM, MemWriteM, MemtoRegM, CacheReadyM;
    logic [REG_AW-1:0]        WA3W;
    logic                     RegWriteW, MemtoRegW;
    logic                     PCSrcE;
    logic [NUM_MC*REG_AW-1:0] McWA3;
    logic [NUM_MC-1:0]        McDone;
    logic                     CntClr;
    logic [1:0]               ForwardAE, ForwardBE;
    logic                     ForwardM;
    logic                     StallF, StallD, StallE, StallM;
    logic                     FlushD, FlushE;
    logic [NUM_MC-1:0]        McGrant, McBusy;
    logic [NUM_REGS-1:0]      Pending;
    logic [CNT_W-1:0]         StallCount;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, McReqD,
        output RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, McStartE,
        output RA2M, WA3M, RegWriteM, MemWriteM, MemtoRegM, CacheReadyM,
        output WA3W, RegWriteW, MemtoRegW, PCSrcE, McWA3, McDone, CntClr,
        input  ForwardAE, ForwardBE, ForwardM, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, McGrant, McBusy, Pending, StallCount
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, McReqD,
        input  RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, McStartE,
        input  RA2M, WA3M, RegWriteM, MemWriteM, MemtoRegM, CacheReadyM,
        input  WA3W, RegWriteW, MemtoRegW, PCSrcE, McWA3, McDone, CntClr,
        output ForwardAE, ForwardBE, ForwardM, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, McGrant, McBusy, Pending, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, stall/flush control and multi-cycle unit scoreboard for the 5-stage pipeline
// Ports: CLK (rising edge), RESETn (asynchronous active-low), bus (hazard_scoreboard_if.slave):
//   inputs  - D/E/M/W register fields and controls, unit start/done/dest, CntClr
//   outputs - ForwardAE/BE/M, StallF/D/E/M, FlushD/E, McGrant, McBusy, Pending, StallCount
module hazard_scoreboard #(
    parameter int REG_AW = 4,
    parameter int NUM_MC = 2,
    parameter int CNT_W  = 16
) (
    input logic                CLK,
    input logic                RESETn,
    hazard_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 2**REG_AW;

    logic [NUM_MC-1:0]   busy, issue, req, grant;
    logic [NUM_REGS-1:0] pending, pend_set, pend_clr;
    logic [CNT_W-1:0]    stall_count;
    logic                ldrstall, cachestall, scbstall, stall_d;

    assign bus.ForwardAE = (bus.RegWriteM && bus.RA1E == bus.WA3M) ? 2'b10 :
                           (bus.RegWriteW && bus.RA1E == bus.WA3W) ? 2'b01 : 2'b00;
    assign bus.ForwardBE = (bus.RegWriteM && bus.RA2E == bus.WA3M) ? 2'b10 :
                           (bus.RegWriteW && bus.RA2E == bus.WA3W) ? 2'b01 : 2'b00;
    assign bus.ForwardM  = (bus.RA2M == bus.WA3W) & bus.MemWriteM & bus.MemtoRegW & bus.RegWriteW;

    assign ldrstall   = ((bus.RA1D == bus.WA3E) | (bus.RA2D == bus.WA3E)) & bus.MemtoRegE & bus.RegWriteE;
    assign cachestall = bus.MemtoRegM & bus.RegWriteM & ~bus.CacheReadyM;
    assign issue      = bus.McStartE & {NUM_MC{~cachestall}};

    // Writeback arbitration: isolate the lowest set request bit (x & -x).
    assign req   = bus.McDone & busy & {NUM_MC{~cachestall}};
    assign grant = req & (~req + NUM_MC'(1));

    assign scbstall = pending[bus.RA1D] | pending[bus.RA2D]
                    | (bus.RegWriteD & pending[bus.WA3D])
                    | ((|bus.McStartE) & bus.RegWriteD & (bus.WA3D == bus.WA3E))
                    | (|(bus.McReqD & busy & ~grant));

    // A grant steals the W write port, so D holds and E gets a bubble that cycle.
    assign stall_d    = ldrstall | scbstall | cachestall | ((|grant) & ~bus.PCSrcE);
    assign bus.StallF = stall_d;
    assign bus.StallD = stall_d;
    assign bus.StallE = cachestall;
    assign bus.StallM = cachestall;
    assign bus.FlushD = bus.PCSrcE;
    assign bus.FlushE = ldrstall | bus.PCSrcE | (|grant) | (scbstall & ~cachestall);

    assign bus.McGrant    = grant;
    assign bus.McBusy     = busy;
    assign bus.Pending    = pending;
    assign bus.StallCount = stall_count;

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            if (issue[i]) pend_set[bus.McWA3[i*REG_AW +: REG_AW]] = 1'b1;
            if (grant[i]) pend_clr[bus.McWA3[i*REG_AW +: REG_AW]] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle issue to a retiring register keeps it pending.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            busy        <= '0;
            pending     <= '0;
            stall_count <= '0;
        end else begin
            busy        <= (busy & ~grant) | issue;
            pending     <= (pending & ~pend_clr) | pend_set;
            stall_count <= bus.CntClr ? '0 :
                           (stall_d && !(&stall_count)) ? stall_count + CNT_W'(1) : stall_count;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table, directed multi-cycle sequences and randomized model check of hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int REG_AW = 4;
    localparam int NUM_MC = 2;
    localparam int CNT_W  = 4;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    hazard_scoreboard_if #(.REG_AW(REG_AW), .NUM_MC(NUM_MC), .CNT_W(CNT_W)) bus ();
    hazard_scoreboard #(.REG_AW(REG_AW), .NUM_MC(NUM_MC), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESETn(RESETn), .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] ra1e, ra2e, wa3m;
        logic       rwm;
        logic [3:0] wa3w;
        logic       rww;
        logic [3:0] ra1d, ra2d, wa3e;
        logic       mre, rwe, mrm, crm, pcs;
        logic [1:0] efa, efb;
        logic       esd, ese, efd, efe;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.RA1D = 0; bus.RA2D = 0; bus.WA3D = 0; bus.RegWriteD = 0; bus.McReqD = 0;
        bus.RA1E = 0; bus.RA2E = 0; bus.WA3E = 0; bus.RegWriteE = 0; bus.MemtoRegE = 0; bus.McStartE = 0;
        bus.RA2M = 0; bus.WA3M = 0; bus.RegWriteM = 0; bus.MemWriteM = 0; bus.MemtoRegM = 0; bus.CacheReadyM = 1;
        bus.WA3W = 0; bus.RegWriteW = 0; bus.MemtoRegW = 0; bus.PCSrcE = 0;
        bus.McWA3 = 0; bus.McDone = 0; bus.CntClr = 0;
    endtask

    task automatic apply(input vec_t v);
        bus.RA1E = v.ra1e; bus.RA2E = v.ra2e; bus.WA3M = v.wa3m; bus.RegWriteM = v.rwm;
        bus.WA3W = v.wa3w; bus.RegWriteW = v.rww; bus.RA1D = v.ra1d; bus.RA2D = v.ra2d;
        bus.WA3E = v.wa3e; bus.MemtoRegE = v.mre; bus.RegWriteE = v.rwe; bus.MemtoRegM = v.mrm;
        bus.CacheReadyM = v.crm; bus.PCSrcE = v.pcs;
    endtask

    function automatic logic [3:0] stalls();
        return {bus.StallF, bus.StallD, bus.StallE, bus.StallM};
    endfunction

    // Reference model state: per-unit busy flag, per-register pending flag, stall counter.
    bit m_busy [NUM_MC];
    bit m_pend [16];
    int m_cnt;

    initial begin
        //        ra1e ra2e wa3m rwm wa3w rww ra1d ra2d wa3e mre rwe mrm crm pcs  efa   efb   esd ese efd efe
        vecs[0] = '{3, 0, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0};
        vecs[1] = '{3, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0};
        vecs[2] = '{2, 6, 2, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 0, 0, 0, 0, 0, 5, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 1};
        vecs[4] = '{4, 4, 4, 1, 4, 1, 5, 0, 5, 1, 0, 0, 1, 0, 2'b10, 2'b10, 0, 0, 0, 0};
        vecs[5] = '{1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
        vecs[6] = '{1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0};
        vecs[7] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1};
        vecs[8] = '{1, 1, 0, 0, 0, 0, 7, 0, 7, 1, 1, 0, 1, 1, 2'b00, 2'b00, 1, 0, 1, 1};
        vecs[9] = '{9, 9, 8, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b01, 0, 0, 0, 0};

        idle();
        #2;
        chk("reset_busy", 32'(bus.McBusy), 0);
        chk("reset_pending", 32'(bus.Pending), 0);
        chk("reset_count", 32'(bus.StallCount), 0);
        chk("reset_grant", 32'(bus.McGrant), 0);
        @(negedge CLK);
        RESETn = 1'b1;

        foreach (vecs[k]) begin
            @(negedge CLK);
            idle();
            apply(vecs[k]);
            #1;
            chk($sformatf("vec%0d_fwdA", k), 32'(bus.ForwardAE), 32'(vecs[k].efa));
            chk($sformatf("vec%0d_fwdB", k), 32'(bus.ForwardBE), 32'(vecs[k].efb));
            chk($sformatf("vec%0d_stall", k), 32'(stalls()),
                32'({vecs[k].esd, vecs[k].esd, vecs[k].ese, vecs[k].ese}));
            chk($sformatf("vec%0d_flush", k), 32'({bus.FlushD, bus.FlushE}), 32'({vecs[k].efd, vecs[k].efe}));
        end

        // RAW on a multi-cycle result: unit 0 writes r7, D reads r7.
        @(negedge CLK); idle();
        bus.McStartE = 2'b01; bus.McWA3 = 8'h07;
        #1 chk("raw_issue_stallD", 32'(bus.StallD), 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK); idle();
            bus.RA1D = 7; bus.McWA3 = 8'h07;
            #1;
            chk("raw_pending", 32'(bus.Pending), 32'h0080);
            chk("raw_stallD", 32'(bus.StallD), 1);
            chk("raw_flushE", 32'(bus.FlushE), 1);
        end
        @(negedge CLK); idle();
        bus.RA1D = 7; bus.McWA3 = 8'h07; bus.McDone = 2'b01;
        #1 chk("raw_grant", 32'(bus.McGrant), 32'b01);
        @(negedge CLK); idle();
        bus.RA1D = 7;
        #1;
        chk("raw_pending_clr", 32'(bus.Pending), 0);
        chk("raw_busy_clr", 32'(bus.McBusy), 0);
        chk("raw_release_stallD", 32'(bus.StallD), 0);

        // Arbitration: both units done together, unit 0 wins first.
        @(negedge CLK); idle();
        bus.McStartE = 2'b11; bus.McWA3 = {4'd9, 4'd8};
        @(negedge CLK); idle();
        bus.McDone = 2'b11; bus.McWA3 = {4'd9, 4'd8};
        #1;
        chk("arb_busy", 32'(bus.McBusy), 32'b11);
        chk("arb_grant0", 32'(bus.McGrant), 32'b01);
        chk("arb_flushE0", 32'(bus.FlushE), 1);
        @(negedge CLK); idle();
        bus.McDone = 2'b11; bus.McWA3 = {4'd9, 4'd8};
        #1;
        chk("arb_pending_mid", 32'(bus.Pending), 32'h0200);
        chk("arb_grant1", 32'(bus.McGrant), 32'b10);
        chk("arb_flushE1", 32'(bus.FlushE), 1);
        @(negedge CLK); idle();
        #1 chk("arb_busy_end", 32'(bus.McBusy), 0);

        // Cache miss for 4 cycles: everything holds, no grant, no issue.
        @(negedge CLK); idle();
        bus.CntClr = 1; bus.McStartE = 2'b01; bus.McWA3 = 8'h02;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK); idle();
            bus.MemtoRegM = 1; bus.RegWriteM = 1; bus.CacheReadyM = 0;
            bus.McDone = 2'b01; bus.McStartE = 2'b10; bus.McWA3 = {4'd3, 4'd2};
            #1;
            chk("miss_stalls", 32'(stalls()), 32'hF);
            chk("miss_grant", 32'(bus.McGrant), 0);
        end
        @(negedge CLK); idle();
        bus.McDone = 2'b01; bus.McWA3 = 8'h02;
        #1;
        chk("miss_count", 32'(bus.StallCount), 4);
        chk("miss_busy", 32'(bus.McBusy), 32'b01);
        chk("miss_grant_after", 32'(bus.McGrant), 32'b01);

        // Counter saturation, then async reset in the middle of an op.
        @(negedge CLK); idle();
        bus.CntClr = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK); idle();
            bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.WA3E = 5; bus.RA2D = 5;
        end
        @(negedge CLK); idle();
        bus.McStartE = 2'b01; bus.McWA3 = 8'h0B;
        #1 chk("sat_count", 32'(bus.StallCount), 15);
        @(negedge CLK); idle();
        #1;
        chk("preRst_busy", 32'(bus.McBusy), 32'b01);
        chk("preRst_pending", 32'(bus.Pending), 32'h0800);
        #2 RESETn = 1'b0;
        #1;
        chk("asyncRst_busy", 32'(bus.McBusy), 0);
        chk("asyncRst_pending", 32'(bus.Pending), 0);
        chk("asyncRst_count", 32'(bus.StallCount), 0);
        @(negedge CLK);
        RESETn = 1'b1;

        // Randomized traffic against the rule-level model.
        foreach (m_busy[i]) m_busy[i] = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            bit ld, cs, scb, sd, fe;
            int g;
            logic [1:0] efa, efb;
            logic [NUM_MC-1:0] ebusy;
            logic [15:0] epend;
            @(negedge CLK);
            bus.RA1D = 4'($urandom_range(0, 3)); bus.RA2D = 4'($urandom_range(0, 3));
            bus.WA3D = 4'($urandom_range(0, 3)); bus.RegWriteD = 1'($urandom_range(0, 1));
            bus.McReqD = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
            bus.RA1E = 4'($urandom_range(0, 3)); bus.RA2E = 4'($urandom_range(0, 3));
            bus.WA3E = 4'($urandom_range(0, 3)); bus.RegWriteE = 1'($urandom_range(0, 1));
            bus.MemtoRegE = ($urandom_range(0, 3) == 0);
            bus.McStartE = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.RA2M = 4'($urandom_range(0, 3)); bus.WA3M = 4'($urandom_range(0, 3));
            bus.RegWriteM = 1'($urandom_range(0, 1)); bus.MemWriteM = 1'($urandom_range(0, 1));
            bus.MemtoRegM = ($urandom_range(0, 3) == 0); bus.CacheReadyM = 1'($urandom_range(0, 1));
            bus.WA3W = 4'($urandom_range(0, 3)); bus.RegWriteW = 1'($urandom_range(0, 1));
            bus.MemtoRegW = 1'($urandom_range(0, 1)); bus.PCSrcE = ($urandom_range(0, 7) == 0);
            bus.McWA3 = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            bus.McDone = 2'($urandom_range(0, 3)); bus.CntClr = ($urandom_range(0, 15) == 0);
            #1;
            efa = (bus.RegWriteM && bus.RA1E == bus.WA3M) ? 2 : (bus.RegWriteW && bus.RA1E == bus.WA3W) ? 1 : 0;
            efb = (bus.RegWriteM && bus.RA2E == bus.WA3M) ? 2 : (bus.RegWriteW && bus.RA2E == bus.WA3W) ? 1 : 0;
            ld = (bus.RA1D == bus.WA3E || bus.RA2D == bus.WA3E) && bus.MemtoRegE && bus.RegWriteE;
            cs = bus.MemtoRegM && bus.RegWriteM && !bus.CacheReadyM;
            g = -1;
            for (int i = 0; i < NUM_MC; i++)
                if (!cs && g < 0 && bus.McDone[i] && m_busy[i]) g = i;
            scb = m_pend[bus.RA1D] || m_pend[bus.RA2D] || (bus.RegWriteD && m_pend[bus.WA3D])
                || (bus.McStartE != 0 && bus.RegWriteD && bus.WA3D == bus.WA3E);
            for (int i = 0; i < NUM_MC; i++)
                if (bus.McReqD[i] && m_busy[i] && i != g) scb = 1;
            sd = ld || scb || cs || (g >= 0 && !bus.PCSrcE);
            fe = ld || bus.PCSrcE || g >= 0 || (scb && !cs);
            foreach (m_busy[i]) ebusy[i] = m_busy[i];
            foreach (m_pend[i]) epend[i] = m_pend[i];
            chk("rnd_fwdA", 32'(bus.ForwardAE), 32'(efa));
            chk("rnd_fwdB", 32'(bus.ForwardBE), 32'(efb));
            chk("rnd_fwdM", 32'(bus.ForwardM),
                32'(bus.RA2M == bus.WA3W && bus.MemWriteM && bus.MemtoRegW && bus.RegWriteW));
            chk("rnd_stall", 32'(stalls()), 32'({sd, sd, cs, cs}));
            chk("rnd_flush", 32'({bus.FlushD, bus.FlushE}), 32'({bus.PCSrcE, fe}));
            chk("rnd_grant", 32'(bus.McGrant), (g >= 0) ? (32'd1 << g) : 32'd0);
            chk("rnd_busy", 32'(bus.McBusy), 32'(ebusy));
            chk("rnd_pending", 32'(bus.Pending), 32'(epend));
            chk("rnd_count", 32'(bus.StallCount), 32'(m_cnt));
            @(posedge CLK);
            if (g >= 0) begin
                m_busy[g] = 0;
                m_pend[bus.McWA3[g*REG_AW +: REG_AW]] = 0;
            end
            for (int i = 0; i < NUM_MC; i++)
                if (bus.McStartE[i] && !cs) begin
                    m_busy[i] = 1;
                    m_pend[bus.McWA3[i*REG_AW +: REG_AW]] = 1;
                end
            m_cnt = bus.CntClr ? 0 : (sd && m_cnt < 15) ? m_cnt + 1 : m_cnt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
